// File: rtl/cursor_pkg.sv
// Shared types, constants and clamp arithmetic for the cursor tracker.
package cursor_pkg;

  typedef enum logic [1:0] {StIdle, StDrain, StPublish} state_e;

  // edge_hit bit positions: {left, right, top, bottom}
  localparam int unsigned EdgeLeft   = 3;
  localparam int unsigned EdgeRight  = 2;
  localparam int unsigned EdgeTop    = 1;
  localparam int unsigned EdgeBottom = 0;

  localparam int unsigned XMaxDef  = 639;
  localparam int unsigned YMaxDef  = 479;
  localparam int unsigned PosWDef  = 10;
  localparam int unsigned DispWDef = 9;
  localparam int unsigned XInitDef = 20;
  localparam int unsigned YInitDef = 20;
  localparam int unsigned DepthDef = 4;

  typedef struct packed {
    logic [31:0] val;
    logic        lo;
    logic        hi;
  } clamp_t;

  function automatic clamp_t clamp_coord(input int v, input int max_v);
    clamp_t r;
    r.val = 32'(v);
    r.lo  = 1'b0;
    r.hi  = 1'b0;
    if (v < 0) begin
      r.val = '0;
      r.lo  = 1'b1;
    end else if (v > max_v) begin
      r.val = 32'(max_v);
      r.hi  = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/disp_fifo.sv
// Show-ahead displacement queue with flush; push while full is taken only alongside a pop.
module disp_fifo #(
  parameter int unsigned Width = 18,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] PtrOne = (AW+1)'(1);

  logic [Width-1:0] mem_q [Depth];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign data_o  = mem_q[rd_q[AW-1:0]];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PtrOne;
      if (do_pop)  rd_d = rd_q + PtrOne;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (do_push && !flush_i) mem_q[wr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/cursor_tracker.sv
// Frame-synchronous cursor accumulator: queued signed deltas are drained and clamped each frame,
// then the new position is published with a one-cycle pos_valid.
module cursor_tracker
  import cursor_pkg::*;
#(
  parameter int unsigned X_MAX  = XMaxDef,
  parameter int unsigned Y_MAX  = YMaxDef,
  parameter int unsigned POS_W  = PosWDef,
  parameter int unsigned DISP_W = DispWDef,
  parameter int unsigned X_INIT = XInitDef,
  parameter int unsigned Y_INIT = YInitDef,
  parameter int unsigned DEPTH  = DepthDef
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_tick,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [DISP_W-1:0] X_displ,
  input  logic [DISP_W-1:0] Y_displ,
  input  logic              set_valid,
  input  logic [POS_W-1:0]  X_set,
  input  logic [POS_W-1:0]  Y_set,
  input  logic              recentre,
  output logic [POS_W-1:0]  X_pos,
  output logic [POS_W-1:0]  Y_pos,
  output logic              pos_valid,
  output logic [3:0]        edge_hit,
  output logic [7:0]        missed_ticks
);

  localparam int unsigned      CntW     = $clog2(DEPTH) + 1;
  localparam int unsigned      FifoW    = 2 * DISP_W;
  localparam logic [CntW-1:0]  DepthCnt = CntW'(DEPTH);
  localparam logic [POS_W-1:0] XInit    = POS_W'(X_INIT);
  localparam logic [POS_W-1:0] YInit    = POS_W'(Y_INIT);

  state_e             state_q, state_d;
  logic [POS_W-1:0]   x_pos_q, x_pos_d, y_pos_q, y_pos_d;
  logic [POS_W-1:0]   work_x_q, work_x_d, work_y_q, work_y_d;
  logic               pos_valid_q, pos_valid_d;
  logic [3:0]         edge_q, edge_d;
  logic [7:0]         miss_q, miss_d;
  logic [CntW-1:0]    pops_q, pops_d;

  logic               fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;
  logic [FifoW-1:0]   fifo_rdata;
  logic signed [DISP_W-1:0]  dx, dy;
  logic signed [POS_W+1:0]   sum_x, sum_y;
  clamp_t             cx, cy, sx, sy;
  logic               unused_clamp;

  assign disp_ready = ~fifo_full;
  assign fifo_push  = disp_valid & ~fifo_full;

  disp_fifo #(
    .Width(FifoW),
    .Depth(DEPTH)
  ) u_fifo (
    .clk_i  (Clk),
    .rst_ni (Reset),
    .flush_i(fifo_flush),
    .push_i (fifo_push),
    .data_i ({X_displ, Y_displ}),
    .pop_i  (fifo_pop),
    .data_o (fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign dx    = fifo_rdata[FifoW-1:DISP_W];
  assign dy    = fifo_rdata[DISP_W-1:0];
  assign sum_x = $signed({2'b00, work_x_q}) + (POS_W+2)'(dx);
  assign sum_y = $signed({2'b00, work_y_q}) + (POS_W+2)'(dy);
  assign cx    = clamp_coord(int'(sum_x), int'(X_MAX));
  assign cy    = clamp_coord(int'(sum_y), int'(Y_MAX));
  assign sx    = clamp_coord(int'({1'b0, X_set}), int'(X_MAX));
  assign sy    = clamp_coord(int'({1'b0, Y_set}), int'(Y_MAX));

  assign unused_clamp = ^{cx.val[31:POS_W], cy.val[31:POS_W], sx.val[31:POS_W],
                          sy.val[31:POS_W], sx.lo, sy.lo};

  always_comb begin
    state_d     = state_q;
    x_pos_d     = x_pos_q;
    y_pos_d     = y_pos_q;
    work_x_d    = work_x_q;
    work_y_d    = work_y_q;
    pos_valid_d = 1'b0;
    edge_d      = edge_q;
    miss_d      = miss_q;
    pops_d      = pops_q;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;

    if (frame_tick && (state_q != StIdle) && (miss_q != 8'hff)) miss_d = miss_q + 8'd1;

    unique case (state_q)
      StIdle: begin
        if (frame_tick) begin
          state_d = StDrain;
          edge_d  = '0;
          pops_d  = '0;
          if (recentre) begin
            work_x_d   = XInit;
            work_y_d   = YInit;
            fifo_flush = 1'b1;
          end else if (set_valid) begin
            work_x_d           = sx.val[POS_W-1:0];
            work_y_d           = sy.val[POS_W-1:0];
            edge_d[EdgeRight]  = sx.hi;
            edge_d[EdgeBottom] = sy.hi;
            fifo_flush         = 1'b1;
          end else begin
            work_x_d = x_pos_q;
            work_y_d = y_pos_q;
          end
        end
      end
      StDrain: begin
        // The pop cap keeps a continuously fed queue from stretching the frame.
        if (fifo_empty || (pops_q == DepthCnt)) begin
          state_d = StPublish;
        end else begin
          fifo_pop           = 1'b1;
          pops_d             = pops_q + CntW'(1);
          work_x_d           = cx.val[POS_W-1:0];
          work_y_d           = cy.val[POS_W-1:0];
          edge_d[EdgeLeft]   = edge_q[EdgeLeft]   | cx.lo;
          edge_d[EdgeRight]  = edge_q[EdgeRight]  | cx.hi;
          edge_d[EdgeTop]    = edge_q[EdgeTop]    | cy.lo;
          edge_d[EdgeBottom] = edge_q[EdgeBottom] | cy.hi;
        end
      end
      StPublish: begin
        x_pos_d     = work_x_q;
        y_pos_d     = work_y_q;
        pos_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= StIdle;
      x_pos_q     <= XInit;
      y_pos_q     <= YInit;
      work_x_q    <= XInit;
      work_y_q    <= YInit;
      pos_valid_q <= 1'b0;
      edge_q      <= '0;
      miss_q      <= '0;
      pops_q      <= '0;
    end else begin
      state_q     <= state_d;
      x_pos_q     <= x_pos_d;
      y_pos_q     <= y_pos_d;
      work_x_q    <= work_x_d;
      work_y_q    <= work_y_d;
      pos_valid_q <= pos_valid_d;
      edge_q      <= edge_d;
      miss_q      <= miss_d;
      pops_q      <= pops_d;
    end
  end

  assign X_pos        = x_pos_q;
  assign Y_pos        = y_pos_q;
  assign pos_valid    = pos_valid_q;
  assign edge_hit     = edge_q;
  assign missed_ticks = miss_q;

endmodule

// File: tb/tb_cursor_tracker.sv
// Scoreboard bench: each recorded frame_tick queues its expected position, flags and latency;
// a negedge monitor pops and compares on every pos_valid.
module tb_cursor_tracker;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       disp_valid = 1'b0;
  logic       disp_ready;
  logic [8:0] X_displ = '0;
  logic [8:0] Y_displ = '0;
  logic       set_valid = 1'b0;
  logic [9:0] X_set = '0;
  logic [9:0] Y_set = '0;
  logic       recentre = 1'b0;
  logic [9:0] X_pos, Y_pos;
  logic       pos_valid;
  logic [3:0] edge_hit;
  logic [7:0] missed_ticks;

  typedef struct {
    int x;
    int y;
    int e;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   tick_cyc = 0;

  cursor_tracker dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_tick  (frame_tick),
    .disp_valid  (disp_valid),
    .disp_ready  (disp_ready),
    .X_displ     (X_displ),
    .Y_displ     (Y_displ),
    .set_valid   (set_valid),
    .X_set       (X_set),
    .Y_set       (Y_set),
    .recentre    (recentre),
    .X_pos       (X_pos),
    .Y_pos       (Y_pos),
    .pos_valid   (pos_valid),
    .edge_hit    (edge_hit),
    .missed_ticks(missed_ticks)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (pos_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_pos_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("frame_x", int'(X_pos), e.x);
        check("frame_y", int'(Y_pos), e.y);
        check("frame_edge", int'(edge_hit), e.e);
        check("frame_latency", cyc - tick_cyc, e.lat);
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input int dx, input int dy);
    disp_valid = 1'b1;
    X_displ    = 9'(dx);
    Y_displ    = 9'(dy);
    step();
    disp_valid = 1'b0;
  endtask

  task automatic tick(input bit rec, input int x, input int y, input int e, input int lat);
    exp_t ex;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    set_valid  = 1'b0;
    recentre   = 1'b0;
    if (rec) begin
      tick_cyc = cyc;
      ex.x = x; ex.y = y; ex.e = e; ex.lat = lat;
      sb.push_back(ex);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      check("frame_timeout", int'(sb.size()), 0);
      sb.delete();
    end
    step();
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x"}, int'(X_pos), 20);
    check({tag, "_y"}, int'(Y_pos), 20);
    check({tag, "_pos_valid"}, int'(pos_valid), 0);
    check({tag, "_edge"}, int'(edge_hit), 0);
    check({tag, "_missed"}, int'(missed_ticks), 0);
    check({tag, "_ready"}, int'(disp_ready), 1);
  endtask

  initial begin
    #1 Reset = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) step();
    Reset = 1'b1;
    step();

    // Empty frame
    tick(1, 20, 20, 0, 2);
    wait_done();

    // Two deltas
    push(5, -3);
    push(100, 7);
    tick(1, 125, 24, 0, 4);
    wait_done();

    // Move to (630,5), then clamp right and top
    X_set = 10'd630; Y_set = 10'd5; set_valid = 1'b1;
    tick(1, 630, 5, 0, 2);
    wait_done();
    push(20, -10);
    tick(1, 639, 0, 4'b0110, 3);
    wait_done();

    // Full queue, refused 5th packet, missed tick
    push(-10, 10);
    push(-20, 20);
    push(-30, 30);
    push(-40, 40);
    check("full_ready", int'(disp_ready), 0);
    disp_valid = 1'b1; X_displ = 9'h1ff; Y_displ = 9'h1ff;
    step();
    disp_valid = 1'b0;
    check("full_ready_hold", int'(disp_ready), 0);
    tick(1, 539, 100, 0, 6);
    tick(0, 0, 0, 0, 0);
    wait_done();
    check("missed_ticks", int'(missed_ticks), 1);

    // Packet accepted mid-DRAIN is drained in the same frame
    push(1, 1);
    tick(1, 542, 103, 0, 4);
    push(2, 2);
    wait_done();

    // set_valid beats queued deltas and flushes them
    push(5, 5);
    push(6, 6);
    X_set = 10'd700; Y_set = 10'd100; set_valid = 1'b1;
    tick(1, 639, 100, 4'b0100, 2);
    wait_done();
    tick(1, 639, 100, 0, 2);
    wait_done();

    // recentre beats set_valid
    push(5, 5);
    X_set = 10'd300; Y_set = 10'd300; set_valid = 1'b1; recentre = 1'b1;
    tick(1, 20, 20, 0, 2);
    wait_done();

    // Reset mid-DRAIN
    X_set = 10'd800; Y_set = 10'd200; set_valid = 1'b1;
    tick(1, 639, 200, 4'b0100, 2);
    wait_done();
    push(1, 1);
    push(1, 1);
    push(1, 1);
    push(1, 1);
    check("pre_reset_ready", int'(disp_ready), 0);
    tick(0, 0, 0, 0, 0);
    step();
    Reset = 1'b0;
    #1 check_reset_outputs("mid_drain_reset");
    repeat (3) step();
    Reset = 1'b1;
    step();
    tick(1, 20, 20, 0, 2);
    wait_done();

    if (sb.size() != 0) check("leftover_expected", int'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
